// File: rtl/sample_window.sv
// sample_window: streaming collector that keeps the last N samples in a
// shift register and offers them as one flattened, registered window with a
// valid/ready handshake. After the first full window, a new window is offered
// every STRIDE accepted samples.
// Optional feature macro: SAMPLE_WINDOW_SUM_EN adds a registered running
// total of the window slots on output `sum`.
module sample_window #(
    parameter int N      = 3,
    parameter int DATAW  = 8,
    parameter int STRIDE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATAW-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [N*DATAW-1:0]         window,
    output logic [$clog2(N+1)-1:0]     count
`ifdef SAMPLE_WINDOW_SUM_EN
    ,
    output logic [DATAW+$clog2(N+1)-1:0] sum
`endif
);

    localparam int CW  = $clog2(N + 1);
    localparam int SCW = $clog2(STRIDE + 1);

    localparam logic [1:0] FILL = 2'b00;
    localparam logic [1:0] HOLD = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;

    logic [DATAW-1:0] r_slot [N];
    logic [CW-1:0]    r_count;
    logic             r_win_valid;
    logic [SCW-1:0]   r_scnt;
    logic [1:0]       r_state;

    logic             w_in_ready;
    logic             w_accept;

    // Input readiness: blocked during flush, follows the consumer while a
    // window is pending so the pending window cannot be overwritten.
    always_comb begin
        w_in_ready = 1'b1;
        if (flush)
            w_in_ready = 1'b0;
        else if (r_state == HOLD)
            w_in_ready = win_ready;
    end

    assign w_accept  = in_valid && w_in_ready;
    assign in_ready  = w_in_ready;
    assign win_valid = r_win_valid;
    assign count     = r_count;

    for (genvar k = 0; k < N; k++) begin : g_flat
        assign window[k*DATAW +: DATAW] = r_slot[k];
    end

    // Sample shift register: newest sample enters slot 0, oldest drops out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) r_slot[k] <= '0;
        end else if (flush) begin
            for (int k = 0; k < N; k++) r_slot[k] <= '0;
        end else if (w_accept) begin
            for (int k = N - 1; k > 0; k--) r_slot[k] <= r_slot[k-1];
            r_slot[0] <= in_data;
        end
    end

    // Fill / hold / run sequencing: count, stride counter and window valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= FILL;
            r_count     <= '0;
            r_scnt      <= '0;
            r_win_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= FILL;
            r_count     <= '0;
            r_scnt      <= '0;
            r_win_valid <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        if (r_count == CW'(N - 1)) begin
                            r_win_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (win_ready) begin
                        if (w_accept) begin
                            // The accepted sample already counts toward the next window.
                            r_scnt <= SCW'(1);
                            if (STRIDE == 1) begin
                                r_win_valid <= 1'b1;
                            end else begin
                                r_win_valid <= 1'b0;
                                r_state     <= RUN;
                            end
                        end else begin
                            r_scnt      <= '0;
                            r_win_valid <= 1'b0;
                            r_state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (r_scnt == SCW'(STRIDE - 1)) begin
                            r_scnt      <= '0;
                            r_win_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_scnt <= r_scnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_win_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SAMPLE_WINDOW_SUM_EN
    localparam int SW = DATAW + CW;

    logic [SW-1:0] r_sum;

    // Running window total: add the incoming sample, drop the oldest slot.
    // Zero-filled slots keep this exact while the window is still filling.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_sum <= '0;
        else if (flush)
            r_sum <= '0;
        else if (w_accept)
            r_sum <= r_sum + SW'(in_data) - SW'(r_slot[N-1]);
    end

    assign sum = r_sum;
`endif

endmodule
